// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter register and instruction fetch sequencer
module pc_sequencer #(
  parameter int unsigned      AW         = 32,
  parameter logic [AW-1:0]    RESET_PC   = '0,
  parameter logic [AW-1:0]    EXC_VECTOR = 32'h00000020
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          imem_ready,
  input  logic          jump,
  input  logic [AW-1:0] jump_target,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  input  logic          exception,
  input  logic [AW-1:0] exc_pc,
  input  logic          halt,
  input  logic          resume,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_plus1,
  output logic          fetch_valid,
  output logic [AW-1:0] epc,
  output logic          flush_if,
  output logic          flush_id,
  output logic          flush_ex,
  output logic          halted
);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] pc_nxt;
  logic [AW-1:0] epc_nxt;
  logic          redirect;

  // Sequential successor wraps naturally at AW bits.
  assign pc_plus1 = pc + AW'(1);

  // Any of the three control-flow redirects seen while running.
  assign redirect = exception | branch_taken | jump;

  // State register; reset always lands in BOOT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: BOOT is a single cycle, a redirect cancels a same-cycle halt.
  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:   state_nxt = S_RUN;
      S_RUN: begin
        if (!redirect && halt) begin
          state_nxt = S_HALTED;
        end
      end
      S_HALTED: begin
        if (exception || resume) begin
          state_nxt = S_RUN;
        end
      end
      default:  state_nxt = S_BOOT;
    endcase
  end

  // Outputs and next-PC selection; everything quiet while reset is high.
  always_comb begin
    fetch_valid = 1'b0;
    halted      = 1'b0;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    pc_nxt      = pc;
    epc_nxt     = epc;
    if (!reset) begin
      case (state)
        S_RUN: begin
          fetch_valid = 1'b1;
          flush_if    = exception | branch_taken | jump;
          flush_id    = exception | branch_taken;
          flush_ex    = exception;
          if (exception) begin
            pc_nxt  = EXC_VECTOR;
            epc_nxt = exc_pc;
          end else if (branch_taken) begin
            pc_nxt = branch_target;
          end else if (jump) begin
            pc_nxt = jump_target;
          end else if (stall || !imem_ready || halt) begin
            pc_nxt = pc;
          end else begin
            pc_nxt = pc_plus1;
          end
        end
        S_HALTED: begin
          halted   = 1'b1;
          flush_if = exception;
          flush_id = exception;
          flush_ex = exception;
          if (exception) begin
            pc_nxt  = EXC_VECTOR;
            epc_nxt = exc_pc;
          end
        end
        default: begin
          pc_nxt = pc;
        end
      endcase
    end
  end

  // PC and EPC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc  <= RESET_PC;
      epc <= '0;
    end else begin
      pc  <= pc_nxt;
      epc <= epc_nxt;
    end
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the program counter register and sequences instruction fetch for the 5-stage pipeline. Each cycle it selects the next word-addressed PC from these sources:
- sequential (PC+1)
- jump target (ID stage)
- branch target (EX stage)
- exception vector
It also honours hazard stalls, instruction-memory back-pressure and halt/resume, and drives the pipeline flush lines for the IF/ID/EX stages.

Parameters:
AW, 32, PC width in bits (word address).
RESET_PC, 0, PC value loaded on reset.
EXC_VECTOR, 32'h00000020, PC value loaded on exception (word address).

Ports:
clk  in  1  rising-edge clock
reset  in  1  reset, synchronous, active-high
stall  in  1  hazard-unit stall; holds PC
imem_ready  in  1  instruction memory accepts the current fetch
jump  in  1  ID-stage jump request
jump_target  in  AW  jump destination
branch_taken  in  1  EX-stage resolved taken branch
branch_target  in  AW  branch destination
exception  in  1  exception raised in EX
exc_pc  in  AW  PC of the faulting instruction
halt  in  1  halt request (break/syscall)
resume  in  1  leave HALTED
pc  out  AW  current fetch address (registered)
pc_plus1  out  AW  pc+1, combinational, for link/sequential use
fetch_valid  out  1  pc is a valid fetch this cycle
epc  out  AW  captured exception PC (registered)
flush_if  out  1  kill IF/ID register contents
flush_id  out  1  kill ID/EX register contents
flush_ex  out  1  kill EX/MEM register contents
halted  out  1  state == HALTED

Behaviour:
- Reset (synchronous, active-high, sampled on posedge clk):
  - pc = RESET_PC, epc = 0, state = BOOT.
  - Reset overrides every other input on that edge.
  - Reset mid-operation (including HALTED) returns to BOOT the next cycle.
- Combinational outputs during reset:
  - fetch_valid = 0, all flushes = 0, halted = 0.
- States:
  - BOOT:
    - Lasts exactly one cycle.
    - fetch_valid = 0, pc holds RESET_PC, all inputs ignored.
    - Always goes to RUN. The first valid fetch of RESET_PC is in the 2nd cycle after reset deasserts.
  - RUN:
    - fetch_valid = 1.
    - Next-PC priority, highest first:
      1. exception: pc <= EXC_VECTOR, epc <= exc_pc.
      2. branch_taken: pc <= branch_target.
      3. jump: pc <= jump_target.
      4. stall or !imem_ready: pc holds.
      5. otherwise: pc <= pc+1.
    - Redirects (1–3) apply even when stall or !imem_ready is high. The outstanding fetch is discarded via the flushes.
    - halt with no redirect in the same cycle: pc holds, next state HALTED.
    - halt with a redirect in the same cycle: the redirect is taken, halt is ignored, and the requester must reassert it.
  - HALTED:
    - fetch_valid = 0, halted = 1, pc holds.
    - exception: vector as in RUN, go to RUN.
    - resume (with no exception): go to RUN with pc unchanged, so the held PC is fetched next.
    - branch/jump/stall are ignored.
- Flushes:
  - Combinational, same cycle as the cause; asserted only in RUN, or in HALTED for exception.
  - flush_if = exception | branch_taken | jump.
  - flush_id = exception | branch_taken.
  - flush_ex = exception.
- epc changes only on an accepted exception.
- Arithmetic:
  - pc_plus1 = pc + 1, truncated to AW bits; all-ones wraps to 0.
  - No byte addressing; increments are by 1 word.
- Latency:
  - A redirect asserted in cycle N is visible on pc in cycle N+1.
  - No bubble beyond the flushed stages.

Test Plan:
- Reset/boot: assert reset 2 cycles, release -> cycle 1 fetch_valid=0 pc=0; then pc = 0, 1, 2, 3 on consecutive cycles with fetch_valid=1.
- Stall/back-pressure:
  - At pc=5, stall=1 for 3 cycles -> pc stays 5, no flushes, then resumes with 6.
  - Repeat with imem_ready=0 -> same result.
- Priority: at pc=10, assert jump (jt=40), branch_taken (bt=80) and stall together -> next pc=80, flush_if=1, flush_id=1, flush_ex=0. Then the same with exception=1, exc_pc=9 -> pc=0x20, epc=9, all three flushes=1.
- Halt/resume:
  - At pc=7, halt=1 -> halted=1, fetch_valid=0, pc=7.
  - jump during HALTED -> pc unchanged.
  - resume -> next cycle fetch_valid=1, pc=7, then 8.
- Wrap and reset: with AW=4, run to pc=15 -> next pc=0 and pc_plus1=1. Assert reset while in HALTED -> BOOT, pc=0, epc=0, halted=0.
